xnor_serial_8bit: RTL and testbench

Bit-serial counterpart of the parallel 8-bit XNOR array. It accepts two serial bit streams, one bit pair per accepted cycle, LSB first. It builds the WIDTH-bit XNOR (bitwise equality) mask over WIDTH accepted beats, then presents it in parallel with an all-equal flag and a done pulse. It sits at the end of a serial link, where operand bytes arrive one bit at a time, and replaces a deserializer followed by a parallel XNOR stage.

---
 rtl/xnor_serial_8bit.sv | 120 ++++++++++++
 tb/tb_xnor_serial_8bit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/xnor_serial_8bit.sv
// xnor_serial_8bit
//   Bit-serial XNOR (bitwise equality) of two operand streams. The streams
//   arrive LSB first, one bit pair per accepted beat. After WIDTH beats the
//   full mask is presented in parallel, together with an all-equal flag and
//   a one-cycle done pulse.
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      synchronous reset, active-high
//   inStart  begin a new word (honoured only in IDLE)
//   inValid  inA/inB bit pair is valid (honoured only in ACCUM)
//   inA      serial operand A bit, LSB first
//   inB      serial operand B bit, LSB first
//   outY     registered XNOR mask of the last completed word
//   outEq    registered, 1 when every bit of outY is 1
//   outDone  one-cycle pulse, outY/outEq updated this cycle
//   outBusy  1 in ACCUM and DONE, 0 in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for inStart; clears counter and mask on start
// ACCUM | accepting one bit pair per valid beat until WIDTH are in
// DONE  | single cycle, new outY/outEq visible with outDone high

module xnor_serial_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inStart,
  input  logic             inValid,
  input  logic             inA,
  input  logic             inB,
  output logic [WIDTH-1:0] outY,
  output logic             outEq,
  output logic             outDone,
  output logic             outBusy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_nxt;
  logic             start_word;
  logic             accept;
  logic             last_beat;

  assign last_beat = (count == CW'(WIDTH - 1));

  // The finishing beat's bit is merged combinationally so outY can be
  // loaded with the complete mask on the same edge that accepts it.
  always_comb begin
    mask_nxt        = mask;
    mask_nxt[count] = ~(inA ^ inB);
  end

  always_comb begin
    state_nxt  = state;
    start_word = 1'b0;
    accept     = 1'b0;
    outBusy    = 1'b0;
    case (state)
      IDLE: begin
        if (inStart) begin
          start_word = 1'b1;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        outBusy = 1'b1;
        if (inValid) begin
          accept = 1'b1;
          if (last_beat) state_nxt = DONE;
        end
      end
      DONE: begin
        outBusy   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      mask    <= '0;
      outY    <= '0;
      outEq   <= 1'b0;
      outDone <= 1'b0;
    end else begin
      state   <= state_nxt;
      outDone <= 1'b0;
      if (start_word) begin
        count <= '0;
        mask  <= '0;
      end
      if (accept) begin
        mask  <= mask_nxt;
        count <= count + CW'(1);
        if (last_beat) begin
          outY    <= mask_nxt;
          outEq   <= &mask_nxt;
          outDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_serial_8bit.sv
module tb_xnor_serial_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       inStart;
  logic       inValid;
  logic       inA;
  logic       inB;
  logic [7:0] outY;
  logic       outEq;
  logic       outDone;
  logic       outBusy;

  int total = 0;
  int bad   = 0;

  // Reference state: last completed word as seen from outside.
  logic [7:0] ref_y;
  logic       ref_eq;

  // Idle cycles inserted before each beat of the next word.
  int stl[8];

  xnor_serial_8bit #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .inStart (inStart),
    .inValid (inValid),
    .inA     (inA),
    .inB     (inB),
    .outY    (outY),
    .outEq   (outEq),
    .outDone (outDone),
    .outBusy (outBusy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 8; i++) stl[i] = 0;
  endtask

  // One complete word. valid_on_start drives a junk valid beat alongside
  // inStart; start_at_b4 re-pulses inStart with beat 4.
  task automatic do_word(input logic [7:0] a, input logic [7:0] b,
                         input bit valid_on_start, input bit start_at_b4,
                         input string tag);
    logic [7:0] exp_y;
    exp_y = ~(a ^ b);
    inStart = 1'b1;
    inValid = valid_on_start;
    inA     = 1'b1;
    inB     = 1'b0;
    tick();
    inStart = 1'b0;
    chk({tag, ".busy_start"}, 32'(outBusy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < stl[i]; s++) begin
        inValid = 1'b0;
        inA     = 1'($urandom);
        inB     = 1'($urandom);
        tick();
        chk({tag, ".stall_done"}, 32'(outDone), 32'd0);
        chk({tag, ".stall_hold"}, 32'(outY), 32'(ref_y));
      end
      inValid = 1'b1;
      inA     = a[i];
      inB     = b[i];
      inStart = start_at_b4 && (i == 4);
      tick();
      inStart = 1'b0;
      if (i < 7) begin
        chk({tag, ".early_done"}, 32'(outDone), 32'd0);
        chk({tag, ".hold_y"}, 32'(outY), 32'(ref_y));
        chk({tag, ".hold_eq"}, 32'(outEq), 32'(ref_eq));
      end
    end
    inValid = 1'b0;
    inA     = 1'b0;
    inB     = 1'b0;
    ref_y   = exp_y;
    ref_eq  = (exp_y == 8'hFF);
    chk({tag, ".done"}, 32'(outDone), 32'd1);
    chk({tag, ".y"}, 32'(outY), 32'(ref_y));
    chk({tag, ".eq"}, 32'(outEq), 32'(ref_eq));
    chk({tag, ".busy_done"}, 32'(outBusy), 32'd1);
    tick();
    chk({tag, ".done_drop"}, 32'(outDone), 32'd0);
    chk({tag, ".busy_drop"}, 32'(outBusy), 32'd0);
    chk({tag, ".y_after"}, 32'(outY), 32'(ref_y));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst     = 1'b1;
    inStart = 1'b0;
    inValid = 1'b0;
    inA     = 1'b0;
    inB     = 1'b0;
    ref_y   = 8'h00;
    ref_eq  = 1'b0;
    clear_stalls();
    tick();
    tick();
    rst = 1'b0;
    chk("reset.y", 32'(outY), 32'd0);
    chk("reset.eq", 32'(outEq), 32'd0);
    chk("reset.done", 32'(outDone), 32'd0);
    chk("reset.busy", 32'(outBusy), 32'd0);
    tick();

    // Contiguous words.
    do_word(8'hA5, 8'hA5, 1'b0, 1'b0, "t1");
    tick();
    do_word(8'hA5, 8'h5A, 1'b0, 1'b0, "t2a");
    do_word(8'h0F, 8'h0E, 1'b0, 1'b0, "t2b");

    // Stalls after beat 2 (3 cycles) and after beat 5 (1 cycle).
    stl[3] = 3;
    stl[6] = 1;
    do_word(8'h3C, 8'h3C, 1'b0, 1'b0, "t3");
    clear_stalls();

    // Ignored inStart-time valid and mid-word inStart.
    do_word(8'h81, 8'h01, 1'b1, 1'b1, "t4");

    // Reset mid-word, then a fresh word.
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inA     = 1'b1;
      inB     = 1'b1;
      tick();
    end
    inValid = 1'b0;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    ref_y   = 8'h00;
    ref_eq  = 1'b0;
    chk("t5.rst_y", 32'(outY), 32'd0);
    chk("t5.rst_eq", 32'(outEq), 32'd0);
    chk("t5.rst_busy", 32'(outBusy), 32'd0);
    chk("t5.rst_done", 32'(outDone), 32'd0);
    do_word(8'hFF, 8'h00, 1'b0, 1'b0, "t5");

    // Back-to-back at the minimum start-to-start period.
    do_word(8'hAA, 8'hAA, 1'b0, 1'b0, "t6a");
    do_word(8'h12, 8'h13, 1'b0, 1'b0, "t6b");

    // Randomized words with random stalls and occasional equal operands.
    for (int w = 0; w < 20; w++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      for (int i = 0; i < 8; i++) stl[i] = int'($urandom_range(0, 2));
      do_word(ra, rb, 1'($urandom), 1'($urandom), "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
